// File: rtl/gcd_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gcd_sched_if : requester and core-side signal bundle for gcd_sched (rev 1.0)
// ---------------------------------------------------------------------------
interface gcd_sched_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ack;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_c;
  logic           busy;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_go;
  logic [W-1:0]   core_c;
  logic           core_done;

  // Environment side: requesters plus the shared gcd core.
  modport master (
    output req_valid, req_a, req_b, core_c, core_done,
    input  req_ack, rsp_valid, rsp_id, rsp_c, busy, core_a, core_b, core_go
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, core_c, core_done,
    output req_ack, rsp_valid, rsp_id, rsp_c, busy, core_a, core_b, core_go
  );
endinterface
`default_nettype wire

// File: rtl/gcd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gcd_sched : round-robin sharing of one gcd core among N requesters (rev 1.0)
// Optional: GCD_SCHED_ZERO_BYPASS_EN answers pairs containing a zero locally.
// ---------------------------------------------------------------------------
module gcd_sched #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  wire logic  clk,
  input  wire logic  rst,
  gcd_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [IDW-1:0] C_LAST = IDW'(N - 1);
  localparam logic [N-1:0]   C_ONE  = N'(1);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt;
  logic [IDW-1:0] r_rsp_id;
  logic [N-1:0]   r_ack;
  logic           r_rsp_valid;
  logic           r_go;
  logic [W-1:0]   r_rsp_c;
  logic [W-1:0]   r_core_a;
  logic [W-1:0]   r_core_b;

  logic           w_any;
  logic [IDW-1:0] w_gnt;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;

  // Lowest pending index at or above r_ptr wins; otherwise lowest pending overall.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any = 1'b1;
        w_gnt = IDW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (i >= int'(r_ptr))) begin
        w_gnt = IDW'(i);
      end
    end
  end

  assign w_a = bus.req_a[int'(w_gnt)*W +: W];
  assign w_b = bus.req_b[int'(w_gnt)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rsp_id    <= '0;
      r_ack       <= '0;
      r_rsp_valid <= 1'b0;
      r_go        <= 1'b0;
      r_rsp_c     <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
    end else begin
      r_ack       <= '0;
      r_go        <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_core_a <= w_a;
            r_core_b <= w_b;
            r_gnt    <= w_gnt;
            r_ack    <= C_ONE << w_gnt;
`ifdef GCD_SCHED_ZERO_BYPASS_EN
            if ((w_a == '0) || (w_b == '0)) begin
              r_rsp_c <= w_a | w_b;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
`else
            r_state  <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: begin
          r_go    <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) begin
            r_rsp_c <= bus.core_c;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_gnt;
          r_ptr       <= (r_gnt == C_LAST) ? '0 : r_gnt + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack   = r_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.core_a    = r_core_a;
  assign bus.core_b    = r_core_b;
  assign bus.core_go   = r_go;

endmodule
`default_nettype wire

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
- Round-robin scheduler that shares one algorithm_gcd datapath instance among N requesters.
- Accepts one operand pair at a time, issues it to the shared core and waits for the core's result-ready bit.
- Returns the result tagged with the requester's index.
- Sits between multiple compiled callers of gcd and a single gcd core, saving area when gcd calls are infrequent.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand/result data width; equals intN of the attached core.
- IDW, 2, requester-index width; must satisfy 2^IDW >= N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  per-requester request pending.
- req_a  in  N*W  operand a; requester i occupies bits [i*W +: W].
- req_b  in  N*W  operand b, same packing as req_a.
- req_ack  out  N  one-hot, one-cycle pulse: operands of the granted requester accepted.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_c  out  W  gcd result.
- busy  out  1  high in any state other than IDLE.
- core_a  out  W  operand a to the core.
- core_b  out  W  operand b to the core.
- core_go  out  1  drives the ready bit of the core's a and b inputs.
- core_c  in  W  result data from the core.
- core_done  in  1  ready bit of the core's result.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ack=0, rsp_valid=0, rsp_id=0, rsp_c=0, busy=0, core_go=0, core_a=0, core_b=0.
- Reset applies in any state. An in-flight operation is discarded and no response is emitted for it. A core_done arriving after reset is ignored because the FSM is in IDLE.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If any req_valid is set, grant g = first set index scanning rr_ptr, rr_ptr+1, ... modulo N.
- In the same cycle: latch req_a[g] and req_b[g] into core_a/core_b, latch g, pulse req_ack[g]. Next state ISSUE.
- Otherwise remain in IDLE with all pulses low.

ISSUE:
- core_go=1 for exactly this one cycle. Next state WAIT.
- core_a and core_b stay stable from the latch cycle until the FSM leaves RESP.

WAIT:
- core_go=0. core_done is sampled only in this state.
- When core_done=1: capture core_c into rsp_c. Next state RESP.
- There is no timeout; the FSM waits indefinitely.

RESP:
- rsp_valid=1 and rsp_id=g for one cycle.
- rr_ptr <= (g+1) mod N, wrapping from N-1 to 0.
- Next state IDLE.

Timing and handshake rules:
- rsp_c holds its value until the next capture.
- Latency from the req_ack cycle to the rsp_valid cycle = 3 + core latency, where core latency is counted in cycles from core_go to the first sampled core_done.
- Minimum spacing between successive acks is 4 cycles.
- A requester must hold req_valid and its operands stable until it sees req_ack. It drops req_valid, or presents a new pair, the cycle after req_ack.
- A request that stays valid in the ack cycle is treated as a new request.
- Simultaneous requests: exactly one grant per IDLE cycle.
- Fairness: a continuously asserted requester is granted within N operations.
- No arithmetic is performed in this block except the rr_ptr modulo increment.

Optional Feature:
- Macro GCD_SCHED_ZERO_BYPASS_EN.
- When defined: in IDLE, if the granted pair has a==0 or b==0, the FSM goes directly to RESP with rsp_c = a|b, i.e. gcd(0,x)=x and gcd(0,0)=0. core_go is never asserted for that pair. Latency from ack to rsp_valid is 1 cycle.
- When undefined: every pair goes through ISSUE/WAIT and the core's result is returned unmodified.

Test Plan:
- Requester 0 sends a=21, b=35; core responds → req_ack=0001, then one core_go pulse, then rsp_valid with rsp_id=0, rsp_c=7, busy low afterwards.
- Requesters 0 and 2 both valid in the same cycle from reset, pairs (12,18) and (9,6) → 0 acked first (rsp 6), then 2 (rsp 3), each ack exactly once.
- All 4 requesters held valid for 8 operations → ack order 0,1,2,3,0,1,2,3, and rr_ptr wraps from 3 to 0.
- rst asserted for 1 cycle during WAIT, with core_done arriving 2 cycles later → no rsp_valid, all outputs at reset values, a subsequent request from 1 is acked first.
- Core stub with 5-cycle latency → rsp_valid exactly 8 cycles after req_ack; core_a/core_b stable throughout.
- Pair (0,9) from requester 3 → with GCD_SCHED_ZERO_BYPASS_EN: rsp_c=9, rsp_id=3, rsp_valid 1 cycle after ack, core_go never high. Without the macro: the pair is issued to the core and the core's output is returned.
